// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan controller.
package seg7_pkg;

    localparam int         N_DIGITS  = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off (bit0 = 1) in the table.
    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg.sv
// Combinational nibble + decimal point to active-low segment encoder.
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Table bit0 is 1, so masking it with ~dp_i yields the active-low dp.
    assign seg_o = hex_seg(nibble_i) & {7'h7F, ~dp_i};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode display scanner with per-slot blanking and
// frame-synchronous value update (pending -> shadow only at frame boundary).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [4*N_DIGITS-1:0]     value_i,
    input  logic [N_DIGITS-1:0]       dp_i,
    input  logic [N_DIGITS-1:0]       en_i,
    input  logic                      load_i,
    output logic                      pending_o,
    output logic                      frame_o,
    output logic [N_DIGITS-1:0]       anodos_o,
    output logic [7:0]                segmentos_o
);

    localparam int             CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);

    if (CLK_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_param_chk
        $error("seg7_scan_ctrl: need CLK_DIV >= 2 and 0 <= BLANK_CYCLES < CLK_DIV");
    end

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   pend_val_q, pend_val_d, shad_val_q, shad_val_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
    logic                    pend_q, pend_d;
    logic                    bnd_q, frame_q;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [7:0]              seg_q, seg_d, enc;
    logic                    boundary, wrap, lit;

    assign wrap     = (cnt_q == CNT_LAST);
    assign boundary = wrap && (idx_q == 2'd3);
    assign lit      = (cnt_q >= CNT_BLANK) && en_i[idx_q];

    hex_to_seg u_enc (
        .nibble_i (shad_val_q[{idx_q, 2'b00} +: 4]),
        .dp_i     (shad_dp_q[idx_q]),
        .seg_o    (enc)
    );

    always_comb begin
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        idx_d      = wrap ? idx_q + 2'd1 : idx_q;
        an_d       = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d      = lit ? enc : SEG_BLANK;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;
        shad_val_d = shad_val_q;
        shad_dp_d  = shad_dp_q;
        // A load landing on the boundary itself goes straight to shadow.
        if (boundary) begin
            pend_d = 1'b0;
            if (load_i) begin
                shad_val_d = value_i;
                shad_dp_d  = dp_i;
            end else if (pend_q) begin
                shad_val_d = pend_val_q;
                shad_dp_d  = pend_dp_q;
            end
        end else if (load_i) begin
            pend_val_d = value_i;
            pend_dp_d  = dp_i;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            shad_val_q <= '0;
            shad_dp_q  <= '0;
            bnd_q      <= 1'b0;
            frame_q    <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            shad_val_q <= shad_val_d;
            shad_dp_q  <= shad_dp_d;
            // frame_o lines up with the output cycle showing idx 0 / cnt 0.
            bnd_q      <= boundary;
            frame_q    <= bnd_q;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign pending_o   = pend_q;
    assign frame_o     = frame_q;
    assign anodos_o    = an_q;
    assign segmentos_o = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed table-driven bench for seg7_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  en_i;
    logic        load_i;
    logic        pending_o;
    logic        frame_o;
    logic [3:0]  anodos_o;
    logic [7:0]  segmentos_o;

    seg7_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .value_i     (value_i),
        .dp_i        (dp_i),
        .en_i        (en_i),
        .load_i      (load_i),
        .pending_o   (pending_o),
        .frame_o     (frame_o),
        .anodos_o    (anodos_o),
        .segmentos_o (segmentos_o)
    );

    always #5 clk_i = ~clk_i;

    // t = rising edges since reset release; outputs at t reflect state t-1.
    typedef struct {
        int          t;
        logic [3:0]  en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic        frm;
        logic        pnd;
    } rec_t;

    rec_t vec[$];
    int   t;
    int   n_chk;
    int   n_pass;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d: got %0h expected %0h", name, t, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    function automatic void add(input int tt, input logic [3:0] en, input logic ld,
                                input logic [15:0] val, input logic [3:0] dp,
                                input logic [3:0] an, input logic [7:0] seg,
                                input logic frm, input logic pnd);
        rec_t r;
        r.t = tt; r.en = en; r.ld = ld; r.val = val; r.dp = dp;
        r.an = an; r.seg = seg; r.frm = frm; r.pnd = pnd;
        vec.push_back(r);
    endfunction

    initial begin
        n_chk = 0; n_pass = 0; t = 0;
        rst_ni = 1'b0; value_i = '0; dp_i = '0; en_i = 4'hF; load_i = 1'b0;

        //   t   en    ld  value    dp     an    seg    frm  pnd
        // frame 0: shadow 0000, load 1A80 mid-frame
        add(  1, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 0, 0);
        add(  2, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 0, 0);
        add(  3, 4'hF, 0, 16'h0000, 4'h0, 4'hE, 8'h03, 0, 0);
        add(  4, 4'hF, 1, 16'h1A80, 4'h0, 4'hE, 8'h03, 0, 1);
        add( 11, 4'hF, 0, 16'h0000, 4'h0, 4'hD, 8'h03, 0, 1);
        add( 31, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h03, 0, 1);
        add( 32, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h03, 0, 0);
        // frame 1: 1A80 scan; queue 1A80 with dp0
        add( 33, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 1, 0);
        add( 34, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 0, 0);
        add( 35, 4'hF, 0, 16'h0000, 4'h0, 4'hE, 8'h03, 0, 0);
        add( 37, 4'hF, 1, 16'h1A80, 4'h1, 4'hE, 8'h03, 0, 1);
        add( 43, 4'hF, 0, 16'h0000, 4'h0, 4'hD, 8'h01, 0, 1);
        add( 51, 4'hF, 0, 16'h0000, 4'h0, 4'hB, 8'h11, 0, 1);
        add( 59, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h9F, 0, 1);
        add( 64, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h9F, 0, 0);
        // frame 2: dp on digit 0, enables 0101, live enable toggle; load FFFF mid-frame
        add( 65, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 1, 0);
        add( 67, 4'h5, 0, 16'h0000, 4'h0, 4'hE, 8'h02, 0, 0);
        add( 68, 4'h0, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 0, 0);
        add( 69, 4'h5, 0, 16'h0000, 4'h0, 4'hE, 8'h02, 0, 0);
        add( 71, 4'h5, 1, 16'hFFFF, 4'h0, 4'hE, 8'h02, 0, 1);
        add( 75, 4'h5, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 0, 1);
        add( 83, 4'h5, 0, 16'h0000, 4'h0, 4'hB, 8'h11, 0, 1);
        add( 91, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h9F, 0, 1);
        add( 95, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h9F, 0, 1);
        add( 96, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h9F, 0, 0);
        // frame 3: FFFF shown; two loads, latest wins
        add( 97, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 1, 0);
        add( 99, 4'hF, 0, 16'h0000, 4'h0, 4'hE, 8'h71, 0, 0);
        add(101, 4'hF, 1, 16'h1111, 4'h0, 4'hE, 8'h71, 0, 1);
        add(107, 4'hF, 0, 16'h0000, 4'h0, 4'hD, 8'h71, 0, 1);
        add(111, 4'hF, 1, 16'h2222, 4'h0, 4'hD, 8'h71, 0, 1);
        add(128, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h71, 0, 0);
        // frame 4: 2222; load 3333 on the boundary cycle
        add(129, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 1, 0);
        add(131, 4'hF, 0, 16'h0000, 4'h0, 4'hE, 8'h25, 0, 0);
        add(139, 4'hF, 0, 16'h0000, 4'h0, 4'hD, 8'h25, 0, 0);
        add(159, 4'hF, 0, 16'h0000, 4'h0, 4'h7, 8'h25, 0, 0);
        add(160, 4'hF, 1, 16'h3333, 4'h0, 4'h7, 8'h25, 0, 0);
        // frame 5: 3333; queue 4444 then reset at idx 2
        add(161, 4'hF, 0, 16'h0000, 4'h0, 4'hF, 8'hFF, 1, 0);
        add(163, 4'hF, 0, 16'h0000, 4'h0, 4'hE, 8'h0D, 0, 0);
        add(166, 4'hF, 1, 16'h4444, 4'h0, 4'hE, 8'h0D, 0, 1);
        add(171, 4'hF, 0, 16'h0000, 4'h0, 4'hD, 8'h0D, 0, 1);
        add(180, 4'hF, 0, 16'h0000, 4'h0, 4'hB, 8'h0D, 0, 1);

        // reset held across edges
        repeat (3) tick();
        chk("rst_an", 32'(anodos_o), 32'hF);
        chk("rst_seg", 32'(segmentos_o), 32'hFF);
        chk("rst_frame", 32'(frame_o), 32'h0);
        chk("rst_pend", 32'(pending_o), 32'h0);
        rst_ni = 1'b1;
        t = 0;

        foreach (vec[i]) begin
            run_to(vec[i].t - 1);
            en_i    = vec[i].en;
            load_i  = vec[i].ld;
            value_i = vec[i].val;
            dp_i    = vec[i].dp;
            tick();
            load_i  = 1'b0;
            chk("an", 32'(anodos_o), 32'(vec[i].an));
            chk("seg", 32'(segmentos_o), 32'(vec[i].seg));
            chk("frame", 32'(frame_o), 32'(vec[i].frm));
            chk("pend", 32'(pending_o), 32'(vec[i].pnd));
        end

        // asynchronous reset mid-frame with a load pending
        rst_ni = 1'b0;
        #2;
        chk("arst_an", 32'(anodos_o), 32'hF);
        chk("arst_seg", 32'(segmentos_o), 32'hFF);
        chk("arst_pend", 32'(pending_o), 32'h0);
        chk("arst_frame", 32'(frame_o), 32'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        en_i   = 4'hF;
        t = 0;
        run_to(3);
        chk("post_rst_an", 32'(anodos_o), 32'hE);
        chk("post_rst_seg", 32'(segmentos_o), 32'h03);
        chk("post_rst_pend", 32'(pending_o), 32'h0);
        run_to(11);
        chk("post_rst_d1", 32'(segmentos_o), 32'h03);
        run_to(33);
        chk("post_rst_frame", 32'(frame_o), 32'h1);
        run_to(35);
        chk("post_rst_nocommit", 32'(segmentos_o), 32'h03);
        chk("post_rst_nocommit_an", 32'(anodos_o), 32'hE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
